apb_slave_rx: RTL and testbench
===============================

# apb_slave_rx

Receive-side endpoint for one slave port of `apb_interconnect`. It samples the interconnect's shared `slave_data` bus whenever its own bit of `slave_valids` is asserted, and buffers each word in a small FIFO. The buffered words drain to a local consumer over a valid/ready handshake. Overflow drops are counted so software and benches can detect lost transfers; one instance sits on each slave index.

## Interface
- `DATA_WIDTH`, 32, width of `slave_data` and `rd_data`
- `NUM_SOURCES`, 4, width of `slave_valids` (number of slave ports on the interconnect)
- `SLAVE_ID`, 0, index of the `slave_valids` bit this instance owns; legal range 0..`NUM_SOURCES`-1
- `DEPTH`, 4, FIFO entries; power of two, at least 2
- `pclk`  in  1  the only clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset; sampled on the `pclk` rising edge
- `slave_data`  in  `DATA_WIDTH`  shared data bus from the interconnect
- `slave_valids`  in  `NUM_SOURCES`  one-hot-per-slave write strobes; only bit `SLAVE_ID` is used
- `rd_ready`  in  1  consumer accepts the head word
- `rd_valid`  out  1  FIFO non-empty; head word presented on `rd_data`
- `rd_data`  out  `DATA_WIDTH`  head word; all zeros while `rd_valid`=0
- `level`  out  $clog2(`DEPTH`+1)  current occupancy, 0..`DEPTH`
- `full`  out  1  `level`==`DEPTH`
- `overflow_cnt`  out  8  dropped-word count; saturates at 255

## Operation
- Push: `push = slave_valids[SLAVE_ID]`, sampled each rising edge.
  - Every cycle the bit is high is one word, so a strobe held for two edges writes two words.
  - Bits other than `SLAVE_ID` and all X/Z on them are ignored.
- Pop: `pop = rd_valid & rd_ready`. `rd_ready` while empty has no effect.
- Storage is a circular buffer with `rd_ptr`/`wr_ptr` of $clog2(`DEPTH`) bits each. Both pointers wrap from `DEPTH`-1 to 0 with no bubble.
- `level` is a separate counter:
  - +1 on accepted push with no pop;
  - -1 on pop with no accepted push;
  - unchanged on both or neither.
- Accept rule: a push is accepted if not full, or if full and a pop happens in the same cycle (write into the slot being freed).
- Drop rule: a push while full with no pop is dropped.
  - Data is discarded; pointers and `level` are unchanged.
  - `overflow_cnt` increments by 1 and stays at 255 once reached.
- Simultaneous push and pop when empty cannot occur: `rd_valid`=0, so no pop happens and the push is accepted.
- `rd_data` = `mem[rd_ptr]` when `rd_valid`, else 0. There is no combinational path from `slave_data` to `rd_data`.
- Word order is preserved exactly. There is no reordering, no duplication and no loss except by the drop rule.

## Timing
- Reset (`reset`=0 at an edge) sets `rd_ptr`=0, `wr_ptr`=0, `level`=0 and `overflow_cnt`=0.
  - Resulting outputs: `rd_valid`=0, `rd_data`=0, `full`=0.
  - Memory contents are not cleared.
  - Reset has priority over a push or pop in the same cycle.
  - A reset mid-stream discards all buffered words.
- Capture latency: a word sampled at edge N is visible on `rd_data` with `rd_valid`=1 after edge N (1 cycle), if the FIFO was empty.
- Pop: the head is consumed at the edge where `rd_valid & rd_ready`=1. The next word, or `rd_valid`=0, appears after that edge.
- Flags:
  - `full` and `level` are registered-derived and update after the same edge as the pointers.
  - `full` deasserts the cycle after a pop with no push.
- Sustained throughput: one push and one pop per cycle at any level, including full.
- All outputs are glitch-free functions of registers; `rd_ready` feeds only next-state logic.

## Test plan
- Reset then idle, `SLAVE_ID`=2, `DEPTH`=4 -> `rd_valid`=0, `rd_data`=0, `level`=0, `full`=0 and `overflow_cnt`=0 for 10 cycles. A strobe on `slave_valids`=4'b1011 produces no push.
- Single transfer: `slave_valids`=4'b0100 with `slave_data`=32'hDEAD_BEEF for one cycle, `rd_ready`=0 -> next cycle `rd_valid`=1, `rd_data`=32'hDEAD_BEEF, `level`=1. Raise `rd_ready` -> after one edge `rd_valid`=0 and `level`=0.
- Fill and overflow: push 1, 2, 3, 4, 5, 6 on consecutive cycles with `rd_ready`=0 -> `full`=1 after the 4th push and `overflow_cnt`=2. Draining yields exactly 1, 2, 3, 4.
- Full with simultaneous push and pop: at `level`=4, push 32'h55 while `rd_ready`=1 -> no drop, `level` stays 4, and the final drained word is 32'h55.
- Wrap-around streaming: 20 consecutive pushes 0..19 with `rd_ready`=1 every cycle -> `level` never exceeds 1, output sequence is 0..19, and `overflow_cnt`=0.
- Reset mid-operation: at `level`=3 with `overflow_cnt`=7, hold `reset`=0 for 1 cycle while pushing -> `level`=0, `overflow_cnt`=0, `rd_valid`=0. A subsequent push of 32'hA5 is the first word out.

Source files
------------

// File: rtl/apb_slave_rx.sv
// apb_slave_rx
//   Receive-side endpoint for one slave port of apb_interconnect. Words on the
//   shared slave_data bus are captured whenever bit SLAVE_ID of slave_valids is
//   high. They are buffered in a DEPTH-entry circular FIFO and drained over a
//   valid/ready handshake. Words pushed while the FIFO is full and not being
//   popped are dropped and counted in a saturating 8-bit counter.
//
// Ports
//   pclk          in   clock, rising edge
//   reset         in   synchronous active-low reset
//   slave_data    in   shared interconnect data bus
//   slave_valids  in   per-slave write strobes, only bit SLAVE_ID used
//   rd_ready      in   consumer accepts head word
//   rd_valid      out  FIFO non-empty
//   rd_data       out  head word, zero while empty
//   level         out  occupancy 0..DEPTH
//   full          out  level == DEPTH
//   overflow_cnt  out  dropped-word count, saturating at 255
module apb_slave_rx #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SOURCES = 4,
  parameter int SLAVE_ID    = 0,
  parameter int DEPTH       = 4
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        slave_data,
  input  logic [NUM_SOURCES-1:0]       slave_valids,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic [7:0]                   overflow_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [LW-1:0]         r_level;
  logic [7:0]            r_ovf;

  logic w_push, w_pop, w_full, w_empty, w_accept, w_drop;
  // Strobes belonging to other slaves are deliberately ignored.
  logic w_unused;
  assign w_unused = ^slave_valids;

  assign w_push   = slave_valids[SLAVE_ID];
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_pop    = !w_empty && rd_ready;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the write can proceed.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  // Storage has no reset; stale contents are unreachable once pointers reset.
  always_ff @(posedge pclk) begin
    if (reset && w_accept) r_mem[r_wr_ptr] <= slave_data;
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_accept && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_accept) r_level <= r_level - LW'(1);
      if (w_drop && r_ovf != 8'hFF) r_ovf <= r_ovf + 8'd1;
    end
  end

  assign rd_valid     = !w_empty;
  assign rd_data      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign level        = r_level;
  assign full         = w_full;
  assign overflow_cnt = r_ovf;
endmodule

// File: tb/tb_apb_slave_rx.sv
module tb_apb_slave_rx;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SID = 2;
  localparam int DEPTH = 4;

  logic          pclk = 0;
  logic          reset;
  logic [DW-1:0] slave_data;
  logic [NS-1:0] slave_valids;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [2:0]    level;
  logic          full;
  logic [7:0]    overflow_cnt;

  apb_slave_rx #(.DATA_WIDTH(DW), .NUM_SOURCES(NS), .SLAVE_ID(SID), .DEPTH(DEPTH)) dut (
    .pclk(pclk), .reset(reset), .slave_data(slave_data), .slave_valids(slave_valids),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .full(full), .overflow_cnt(overflow_cnt)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of buffered words plus a drop counter.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] outq[$];
  int            movf = 0;
  int            maxlvl = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("rd_valid", DW'(rd_valid), DW'(mq.size() != 0));
    chk("rd_data", rd_data, (mq.size() != 0) ? mq[0] : '0);
    chk("level", DW'(level), DW'(mq.size()));
    chk("full", DW'(full), DW'(mq.size() == DEPTH));
    chk("overflow_cnt", DW'(overflow_cnt), DW'(movf));
  endtask

  // One clock: update the model with the inputs present at the edge, then check.
  task automatic step();
    bit p, pp;
    @(posedge pclk);
    p  = (slave_valids[SID] === 1'b1);
    pp = (mq.size() != 0) && (rd_ready === 1'b1);
    if (reset !== 1'b1) begin
      mq.delete();
      movf = 0;
    end else begin
      if (pp) outq.push_back(mq.pop_front());
      if (p) begin
        if (mq.size() < DEPTH) mq.push_back(slave_data);
        else if (movf < 255) movf++;
      end
    end
    if (mq.size() > maxlvl) maxlvl = mq.size();
    #1;
    chk_outputs();
  endtask

  task automatic drive(input bit psh, input logic [DW-1:0] d, input bit rdy);
    slave_valids = psh ? 4'b0100 : 4'b0000;
    slave_data   = d;
    rd_ready     = rdy;
  endtask

  task automatic do_reset();
    reset = 0;
    drive(0, '0, 0);
    step();
    reset = 1;
  endtask

  initial begin
    logic [DW-1:0] exp_seq[$];
    reset = 0;
    drive(0, '0, 0);
    step();
    step();
    reset = 1;

    // Idle after reset, then foreign strobes (including X) must not push.
    for (int i = 0; i < 10; i++) step();
    slave_valids = 4'b1011; slave_data = 32'h1234_5678; step();
    slave_valids = 4'bx0xx; step();
    chk("no_push_foreign", DW'(level), 0);

    // Single transfer.
    drive(1, 32'hDEAD_BEEF, 0); step();
    chk("single_data", rd_data, 32'hDEAD_BEEF);
    drive(0, '0, 1); step();
    chk("single_drained", DW'(rd_valid), 0);

    // Fill and overflow.
    outq.delete();
    for (int i = 1; i <= 6; i++) begin
      drive(1, DW'(i), 0); step();
      if (i == 4) chk("full_after_4", DW'(full), 1);
    end
    chk("ovf_2", DW'(overflow_cnt), 2);
    drive(0, '0, 1);
    for (int i = 0; i < 5; i++) step();
    exp_seq = '{32'd1, 32'd2, 32'd3, 32'd4};
    chk("drain_count", DW'(outq.size()), 4);
    foreach (exp_seq[i]) if (i < outq.size()) chk("drain_word", outq[i], exp_seq[i]);

    // Full with simultaneous push and pop.
    do_reset(); outq.delete();
    for (int i = 0; i < 4; i++) begin drive(1, DW'(32'h10 + i), 0); step(); end
    drive(1, 32'h55, 1); step();
    chk("fullpp_level", DW'(level), 4);
    chk("fullpp_ovf", DW'(overflow_cnt), 0);
    drive(0, '0, 1);
    for (int i = 0; i < 5; i++) step();
    chk("fullpp_last", (outq.size() == 5) ? outq[4] : 'x, 32'h55);

    // Wrap-around streaming.
    do_reset(); outq.delete(); maxlvl = 0;
    for (int i = 0; i < 20; i++) begin drive(1, DW'(i), 1); step(); end
    drive(0, '0, 1); step();
    chk("stream_maxlvl", DW'(maxlvl), 1);
    chk("stream_count", DW'(outq.size()), 20);
    for (int i = 0; i < 20 && i < outq.size(); i++) chk("stream_word", outq[i], DW'(i));
    chk("stream_ovf", DW'(overflow_cnt), 0);

    // Reset mid-operation at level 3, overflow 7.
    do_reset(); outq.delete();
    for (int i = 0; i < 11; i++) begin drive(1, DW'(32'h100 + i), 0); step(); end
    drive(0, '0, 1); step();
    chk("pre_rst_level", DW'(level), 3);
    chk("pre_rst_ovf", DW'(overflow_cnt), 7);
    reset = 0; drive(1, 32'hFFFF_0000, 1); step();
    reset = 1;
    chk("rst_level", DW'(level), 0);
    chk("rst_ovf", DW'(overflow_cnt), 0);
    chk("rst_valid", DW'(rd_valid), 0);
    drive(1, 32'hA5, 0); step();
    chk("post_rst_head", rd_data, 32'hA5);

    // Overflow counter saturation.
    do_reset();
    for (int i = 0; i < 264; i++) begin drive(1, DW'(i), 0); step(); end
    chk("ovf_sat", DW'(overflow_cnt), 255);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset        = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      slave_valids = NS'($urandom);
      slave_data   = $urandom;
      rd_ready     = ($urandom_range(0, 2) != 0);
      step();
    end
    reset = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
